// File: rtl/tl_d_pkg.sv
// TileLink D-channel definitions shared by the GrantAck source: opcodes and beats per message.
// Pure combinational helpers; no state, no handshake.
package tl_d_pkg;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1,
    D_HINT_ACK        = 3'd2,
    D_GRANT           = 3'd4,
    D_GRANT_DATA      = 3'd5,
    D_RELEASE_ACK     = 3'd6
  } d_opcode_e;

  // Wide enough for 2^7 bytes at one byte per beat.
  localparam int BEATS_W = 8;
  typedef logic [BEATS_W-1:0] beats_t;

  function automatic logic d_has_data(input logic [2:0] opcode);
    return (opcode == D_ACCESS_ACK_DATA) || (opcode == D_GRANT_DATA);
  endfunction

  function automatic logic d_is_grant(input logic [2:0] opcode);
    return (opcode == D_GRANT) || (opcode == D_GRANT_DATA);
  endfunction

  function automatic beats_t d_beats(input logic [2:0] opcode, input logic [2:0] size,
                                     input int unsigned beat_bytes);
    int unsigned lg;
    beats_t      n;
    lg = $clog2(beat_bytes);
    n  = beats_t'(1);
    if (d_has_data(opcode) && (32'(size) > lg))
      n = beats_t'(1) << (32'(size) - lg);
    return n;
  endfunction

endpackage

// File: rtl/grant_ack_source_ack_fifo.sv
// GrantAck sink-id queue; latency 1 cycle enq->deq (never flows through).
// Backpressure: enq_rdy low when DEPTH entries held; deq holds head until deq_rdy.
module ack_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_vld,
  output logic             enq_rdy,
  input  logic [WIDTH-1:0] enq_dat,
  output logic             deq_vld,
  input  logic             deq_rdy,
  output logic [WIDTH-1:0] deq_dat
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             enq;
  logic             deq;

  assign enq_rdy = (count != CNT_W'(DEPTH));
  assign deq_vld = (count != '0);
  assign deq_dat = mem[rd_ptr];
  assign enq     = enq_vld & enq_rdy;
  assign deq     = deq_vld & deq_rdy;

  // Pointers wrap on their own since DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clock) begin
    if (enq) mem[wr_ptr] <= enq_dat;
  end

endmodule

// File: rtl/grant_ack_source.sv
// Forwards D beats combinationally and queues a GrantAck per completed Grant/GrantData.
// Latency: D->out 0 cycles, last Grant beat->E 1 cycle; backpressure: only a last Grant beat stalls, when the ack queue is full.
module grant_ack_source
  import tl_d_pkg::*;
#(
  parameter int unsigned BEAT_BYTES = 8,
  parameter int          SINK_BITS  = 3,
  parameter int          ACK_DEPTH  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_d_valid,
  output logic                 io_d_ready,
  input  logic [2:0]           io_d_bits_opcode,
  input  logic [2:0]           io_d_bits_size,
  input  logic [SINK_BITS-1:0] io_d_bits_sink,
  output logic                 io_out_valid,
  input  logic                 io_out_ready,
  output logic [2:0]           io_out_bits_opcode,
  output logic [2:0]           io_out_bits_size,
  output logic [SINK_BITS-1:0] io_out_bits_sink,
  output logic                 io_e_valid,
  input  logic                 io_e_ready,
  output logic [SINK_BITS-1:0] io_e_bits_sink
);
  beats_t beat_cnt;
  beats_t msg_beats;
  logic   last_beat;
  logic   grant_beat;
  logic   stall;
  logic   d_fire;
  logic   ack_enq_vld;
  logic   ack_enq_rdy;
  logic   ack_deq_vld;

  assign msg_beats  = d_beats(io_d_bits_opcode, io_d_bits_size, BEAT_BYTES);
  assign last_beat  = (beat_cnt == msg_beats - beats_t'(1));
  assign grant_beat = d_is_grant(io_d_bits_opcode);

  // Held in reset the queue is about to be emptied, so never stall then.
  assign stall = ~reset & grant_beat & last_beat & ~ack_enq_rdy;

  assign io_out_valid       = io_d_valid & ~stall;
  assign io_d_ready         = io_out_ready & ~stall;
  assign io_out_bits_opcode = io_d_bits_opcode;
  assign io_out_bits_size   = io_d_bits_size;
  assign io_out_bits_sink   = io_d_bits_sink;

  assign d_fire      = io_d_valid & io_d_ready;
  assign ack_enq_vld = d_fire & grant_beat & last_beat;

  always_ff @(posedge clock) begin
    if (reset)
      beat_cnt <= '0;
    else if (d_fire)
      beat_cnt <= last_beat ? '0 : beat_cnt + beats_t'(1);
  end

  ack_fifo #(
    .DEPTH (ACK_DEPTH),
    .WIDTH (SINK_BITS)
  ) u_ack_fifo (
    .clock   (clock),
    .reset   (reset),
    .enq_vld (ack_enq_vld),
    .enq_rdy (ack_enq_rdy),
    .enq_dat (io_d_bits_sink),
    .deq_vld (ack_deq_vld),
    .deq_rdy (io_e_ready & ~reset),
    .deq_dat (io_e_bits_sink)
  );

  assign io_e_valid = ack_deq_vld & ~reset;

endmodule

// File: tb/tb_grant_ack_source.sv
// Bench for grant_ack_source: directed scenarios plus random traffic against a queue-based model.
module tb_grant_ack_source;
  localparam int BEAT_BYTES = 8;
  localparam int SINK_BITS  = 3;
  localparam int ACK_DEPTH  = 4;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 io_d_valid;
  logic                 io_d_ready;
  logic [2:0]           io_d_bits_opcode;
  logic [2:0]           io_d_bits_size;
  logic [SINK_BITS-1:0] io_d_bits_sink;
  logic                 io_out_valid;
  logic                 io_out_ready;
  logic [2:0]           io_out_bits_opcode;
  logic [2:0]           io_out_bits_size;
  logic [SINK_BITS-1:0] io_out_bits_sink;
  logic                 io_e_valid;
  logic                 io_e_ready;
  logic [SINK_BITS-1:0] io_e_bits_sink;

  int checks = 0;
  int errors = 0;

  // Reference model: beat index within the current message and the queue of pending acks.
  int m_beat = 0;
  int ackq[$];

  grant_ack_source #(
    .BEAT_BYTES (BEAT_BYTES),
    .SINK_BITS  (SINK_BITS),
    .ACK_DEPTH  (ACK_DEPTH)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .io_d_valid         (io_d_valid),
    .io_d_ready         (io_d_ready),
    .io_d_bits_opcode   (io_d_bits_opcode),
    .io_d_bits_size     (io_d_bits_size),
    .io_d_bits_sink     (io_d_bits_sink),
    .io_out_valid       (io_out_valid),
    .io_out_ready       (io_out_ready),
    .io_out_bits_opcode (io_out_bits_opcode),
    .io_out_bits_size   (io_out_bits_size),
    .io_out_bits_sink   (io_out_bits_sink),
    .io_e_valid         (io_e_valid),
    .io_e_ready         (io_e_ready),
    .io_e_bits_sink     (io_e_bits_sink)
  );

  always #5 clock = ~clock;

  function automatic int m_beats(input int op, input int size);
    int n;
    n = 1;
    if (op == 1 || op == 5) begin
      n = (1 << size) / BEAT_BYTES;
      if (n < 1) n = 1;
    end
    return n;
  endfunction

  function automatic bit m_last();
    return m_beat == m_beats(int'(io_d_bits_opcode), int'(io_d_bits_size)) - 1;
  endfunction

  function automatic bit m_grant();
    return (io_d_bits_opcode == 3'd4) || (io_d_bits_opcode == 3'd5);
  endfunction

  function automatic bit m_stall();
    return !reset && m_grant() && m_last() && (ackq.size() == ACK_DEPTH);
  endfunction

  // Advance the model across one rising edge using the inputs the DUT samples there.
  task automatic tick();
    bit st;
    bit last;
    bit grant;
    @(posedge clock);
    st    = m_stall();
    last  = m_last();
    grant = m_grant();
    if (reset) begin
      m_beat = 0;
      ackq.delete();
    end else begin
      if (ackq.size() > 0 && io_e_ready) void'(ackq.pop_front());
      if (io_d_valid && io_out_ready && !st) begin
        if (last) begin
          m_beat = 0;
          if (grant) ackq.push_back(int'(io_d_bits_sink));
        end else begin
          m_beat++;
        end
      end
    end
    #1;
  endtask

  task automatic drive_d(input bit vld, input int op, input int size, input int sink);
    io_d_valid       = vld;
    io_d_bits_opcode = 3'(op);
    io_d_bits_size   = 3'(size);
    io_d_bits_sink   = 3'(sink);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    io_out_ready = 1'b1;
    io_e_ready   = 1'b1;
    drive_d(1, 4, 0, 3);
    @(negedge clock);
    checks++; if (io_e_valid !== 1'b0) begin errors++; $display("FAIL rst_e_valid: got %b want 0", io_e_valid); end
    checks++; if (io_out_valid !== 1'b1) begin errors++; $display("FAIL rst_out_valid: got %b want 1", io_out_valid); end
    checks++; if (io_d_ready !== 1'b1) begin errors++; $display("FAIL rst_d_ready: got %b want 1", io_d_ready); end
    tick();
    tick();
    reset = 1'b0;
    drive_d(0, 0, 0, 0);
    @(negedge clock);
    checks++; if (io_e_valid !== 1'b0) begin errors++; $display("FAIL post_rst_e_valid: got %b want 0", io_e_valid); end
    checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid: got %b want 0", io_out_valid); end
    tick();
  endtask

  task automatic test_single_grant();
    io_out_ready = 1'b1;
    io_e_ready   = 1'b1;
    drive_d(1, 4, 0, 5);
    @(negedge clock);
    checks++; if (io_out_valid !== 1'b1) begin errors++; $display("FAIL g1_out_valid: got %b want 1", io_out_valid); end
    checks++; if (io_d_ready !== 1'b1) begin errors++; $display("FAIL g1_d_ready: got %b want 1", io_d_ready); end
    checks++; if (io_out_bits_sink !== 3'd5) begin errors++; $display("FAIL g1_out_sink: got %0d want 5", io_out_bits_sink); end
    checks++; if (io_out_bits_opcode !== 3'd4) begin errors++; $display("FAIL g1_out_opcode: got %0d want 4", io_out_bits_opcode); end
    checks++; if (io_e_valid !== 1'b0) begin errors++; $display("FAIL g1_no_flowthrough: got %b want 0", io_e_valid); end
    tick();
    drive_d(0, 0, 0, 0);
    @(negedge clock);
    checks++; if (io_e_valid !== 1'b1) begin errors++; $display("FAIL g1_e_valid: got %b want 1", io_e_valid); end
    checks++; if (io_e_bits_sink !== 3'd5) begin errors++; $display("FAIL g1_e_sink: got %0d want 5", io_e_bits_sink); end
    tick();
    @(negedge clock);
    checks++; if (io_e_valid !== 1'b0) begin errors++; $display("FAIL g1_drained: got %b want 0", io_e_valid); end
    tick();
  endtask

  task automatic test_grant_data();
    io_out_ready = 1'b1;
    io_e_ready   = 1'b1;
    drive_d(1, 5, 6, 2);
    for (int b = 0; b < 8; b++) begin
      @(negedge clock);
      checks++; if (io_d_ready !== 1'b1) begin errors++; $display("FAIL gd_d_ready beat %0d: got %b want 1", b, io_d_ready); end
      checks++; if (io_e_valid !== 1'b0) begin errors++; $display("FAIL gd_early_ack beat %0d: got %b want 0", b, io_e_valid); end
      tick();
    end
    drive_d(0, 0, 0, 0);
    @(negedge clock);
    checks++; if (io_e_valid !== 1'b1) begin errors++; $display("FAIL gd_e_valid: got %b want 1", io_e_valid); end
    checks++; if (io_e_bits_sink !== 3'd2) begin errors++; $display("FAIL gd_e_sink: got %0d want 2", io_e_bits_sink); end
    tick();
    @(negedge clock);
    checks++; if (io_e_valid !== 1'b0) begin errors++; $display("FAIL gd_single_ack: got %b want 0", io_e_valid); end
    tick();
  endtask

  task automatic test_full_stall();
    io_out_ready = 1'b1;
    io_e_ready   = 1'b0;
    for (int s = 0; s < 4; s++) begin
      drive_d(1, 4, 0, s);
      @(negedge clock);
      checks++; if (io_d_ready !== 1'b1) begin errors++; $display("FAIL fs_accept %0d: got %b want 1", s, io_d_ready); end
      tick();
    end
    drive_d(1, 4, 0, 4);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++; if (io_d_ready !== 1'b0) begin errors++; $display("FAIL fs_stall_d_ready: got %b want 0", io_d_ready); end
      checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL fs_stall_out_valid: got %b want 0", io_out_valid); end
      checks++; if (io_e_bits_sink !== 3'd0) begin errors++; $display("FAIL fs_head_stable: got %0d want 0", io_e_bits_sink); end
      tick();
    end
    io_e_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checks++; if (io_e_valid !== 1'b1) begin errors++; $display("FAIL fs_drain_valid %0d: got %b want 1", k, io_e_valid); end
      checks++; if (io_e_bits_sink !== 3'(k)) begin errors++; $display("FAIL fs_drain_sink: got %0d want %0d", io_e_bits_sink, k); end
      if (k == 0) begin
        checks++; if (io_d_ready !== 1'b0) begin errors++; $display("FAIL fs_still_full: got %b want 0", io_d_ready); end
      end
      if (k == 1) begin
        checks++; if (io_d_ready !== 1'b1) begin errors++; $display("FAIL fs_room: got %b want 1", io_d_ready); end
      end
      tick();
      if (k == 1) drive_d(0, 0, 0, 0);
    end
    @(negedge clock);
    checks++; if (io_e_valid !== 1'b0) begin errors++; $display("FAIL fs_empty: got %b want 0", io_e_valid); end
    tick();
  endtask

  task automatic test_passthrough();
    io_e_ready = 1'b1;
    drive_d(1, 1, 5, 0);
    for (int b = 0; b < 5; b++) begin
      io_out_ready = (b != 2);
      @(negedge clock);
      checks++; if (io_out_valid !== 1'b1 || io_out_bits_opcode !== 3'd1 || io_out_bits_size !== 3'd5) begin
        errors++; $display("FAIL pt_aad_out: got v=%b op=%0d sz=%0d want v=1 op=1 sz=5", io_out_valid, io_out_bits_opcode, io_out_bits_size);
      end
      checks++; if (io_d_ready !== io_out_ready) begin errors++; $display("FAIL pt_d_ready: got %b want %b", io_d_ready, io_out_ready); end
      checks++; if (io_e_valid !== 1'b0) begin errors++; $display("FAIL pt_no_ack: got %b want 0", io_e_valid); end
      tick();
    end
    io_out_ready = 1'b1;
    drive_d(1, 6, 0, 1);
    @(negedge clock);
    checks++; if (io_out_valid !== 1'b1 || io_d_ready !== 1'b1 || io_out_bits_opcode !== 3'd6) begin
      errors++; $display("FAIL pt_release_ack: got v=%b r=%b op=%0d want v=1 r=1 op=6", io_out_valid, io_d_ready, io_out_bits_opcode);
    end
    tick();
    drive_d(0, 0, 0, 0);
    @(negedge clock);
    checks++; if (io_e_valid !== 1'b0) begin errors++; $display("FAIL pt_no_ack_after: got %b want 0", io_e_valid); end
    tick();
  endtask

  task automatic test_full_simultaneous();
    int exp_s[4] = '{2, 3, 4, 6};
    io_out_ready = 1'b1;
    io_e_ready   = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      drive_d(1, 4, 0, s);
      tick();
    end
    drive_d(1, 4, 0, 6);
    io_e_ready = 1'b1;
    @(negedge clock);
    checks++; if (io_d_ready !== 1'b0 || io_out_valid !== 1'b0) begin
      errors++; $display("FAIL sim_stall: got r=%b v=%b want r=0 v=0", io_d_ready, io_out_valid);
    end
    checks++; if (io_e_valid !== 1'b1 || io_e_bits_sink !== 3'd1) begin
      errors++; $display("FAIL sim_head: got v=%b sink=%0d want v=1 sink=1", io_e_valid, io_e_bits_sink);
    end
    tick();
    io_e_ready = 1'b0;
    @(negedge clock);
    checks++; if (io_d_ready !== 1'b1) begin errors++; $display("FAIL sim_accept_next: got %b want 1", io_d_ready); end
    tick();
    @(negedge clock);
    checks++; if (io_d_ready !== 1'b0) begin errors++; $display("FAIL sim_full_again: got %b want 0", io_d_ready); end
    tick();
    drive_d(0, 0, 0, 0);
    io_e_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checks++; if (io_e_valid !== 1'b1 || io_e_bits_sink !== 3'(exp_s[k])) begin
        errors++; $display("FAIL sim_drain %0d: got v=%b sink=%0d want v=1 sink=%0d", k, io_e_valid, io_e_bits_sink, exp_s[k]);
      end
      tick();
    end
    @(negedge clock);
    checks++; if (io_e_valid !== 1'b0) begin errors++; $display("FAIL sim_empty: got %b want 0", io_e_valid); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    io_out_ready = 1'b1;
    io_e_ready   = 1'b0;
    drive_d(1, 4, 0, 1);
    tick();
    drive_d(1, 4, 0, 2);
    tick();
    drive_d(1, 5, 6, 3);
    for (int b = 0; b < 3; b++) tick();
    @(negedge clock);
    checks++; if (io_e_valid !== 1'b1 || io_e_bits_sink !== 3'd1) begin
      errors++; $display("FAIL rmb_queued: got v=%b sink=%0d want v=1 sink=1", io_e_valid, io_e_bits_sink);
    end
    reset = 1'b1;
    drive_d(0, 0, 0, 0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    checks++; if (io_e_valid !== 1'b0) begin errors++; $display("FAIL rmb_flushed: got %b want 0", io_e_valid); end
    io_e_ready = 1'b1;
    drive_d(1, 4, 0, 7);
    @(negedge clock);
    checks++; if (io_d_ready !== 1'b1) begin errors++; $display("FAIL rmb_grant_ready: got %b want 1", io_d_ready); end
    tick();
    drive_d(0, 0, 0, 0);
    @(negedge clock);
    checks++; if (io_e_valid !== 1'b1 || io_e_bits_sink !== 3'd7) begin
      errors++; $display("FAIL rmb_ack7: got v=%b sink=%0d want v=1 sink=7", io_e_valid, io_e_bits_sink);
    end
    tick();
    @(negedge clock);
    checks++; if (io_e_valid !== 1'b0) begin errors++; $display("FAIL rmb_one_ack: got %b want 0", io_e_valid); end
    tick();
  endtask

  task automatic test_random();
    int op_tab[6] = '{0, 1, 2, 4, 5, 6};
    for (int c = 0; c < 3000; c++) begin
      int  op;
      int  size;
      bit  st;
      bit  ev;
      reset = ($urandom_range(0, 249) == 0);
      // New message fields only between messages; mid-burst the fields are held.
      if (m_beat == 0) begin
        op   = op_tab[$urandom_range(0, 5)];
        size = (op == 1 || op == 5) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 7));
        drive_d($urandom_range(0, 3) != 0, op, size, int'($urandom_range(0, 7)));
      end else begin
        io_d_valid = ($urandom_range(0, 3) != 0);
      end
      io_out_ready = ($urandom_range(0, 3) != 0);
      io_e_ready   = ($urandom_range(0, 2) == 0);
      @(negedge clock);
      st = m_stall();
      ev = !reset && (ackq.size() > 0);
      checks++; if (io_out_valid !== (io_d_valid && !st)) begin
        errors++; $display("FAIL rnd_out_valid cyc %0d: got %b want %b", c, io_out_valid, io_d_valid && !st);
      end
      checks++; if (io_d_ready !== (io_out_ready && !st)) begin
        errors++; $display("FAIL rnd_d_ready cyc %0d: got %b want %b", c, io_d_ready, io_out_ready && !st);
      end
      checks++; if (io_e_valid !== ev) begin
        errors++; $display("FAIL rnd_e_valid cyc %0d: got %b want %b", c, io_e_valid, ev);
      end
      if (ev) begin
        checks++; if (io_e_bits_sink !== 3'(ackq[0])) begin
          errors++; $display("FAIL rnd_e_sink cyc %0d: got %0d want %0d", c, io_e_bits_sink, ackq[0]);
        end
      end
      checks++; if ({io_out_bits_opcode, io_out_bits_size, io_out_bits_sink} !== {io_d_bits_opcode, io_d_bits_size, io_d_bits_sink}) begin
        errors++; $display("FAIL rnd_out_bits cyc %0d: got %h want %h", c,
                           {io_out_bits_opcode, io_out_bits_size, io_out_bits_sink}, {io_d_bits_opcode, io_d_bits_size, io_d_bits_sink});
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    io_out_ready = 1'b0;
    io_e_ready   = 1'b0;
    drive_d(0, 0, 0, 0);
    test_reset();
    test_single_grant();
    test_grant_data();
    test_full_stall();
    test_passthrough();
    test_full_simultaneous();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
